// File: rtl/spi_bus_pkg.sv
// spi_bus_pkg: shared types and constants for the SPI-to-bus bridge.
//   WORD_WIDTH_DEFAULT : bits per SPI frame / bus word
//   frame_state_t      : frame FSM states (IDLE, SHIFT)
//   tx_state_t         : TX holding register states (EMPTY, FULL, SENDING)
//   CMD_LOAD, CMD_READ : Controller command opcodes carried over SPI
package spi_bus_pkg;

  localparam int WORD_WIDTH_DEFAULT = 16;

  typedef enum logic {
    IDLE,
    SHIFT
  } frame_state_t;

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    SENDING
  } tx_state_t;

  localparam logic [15:0] CMD_LOAD = 16'h3000;
  localparam logic [15:0] CMD_READ = 16'h6000;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for an asynchronous SPI pin with
// single-cycle rise/fall strobes taken from the synchronised level.
//   clk, reset : system clock, synchronous active-high reset
//   din        : asynchronous input pin
//   rise, fall : one-cycle strobes on a synchronised 0->1 / 1->0 transition
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;

  assign sync_d[0] = din;
  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_chain
    assign sync_d[gi] = sync_q[gi-1];
  end

  // Reset loads the pin's idle level so leaving reset creates no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_bus_bridge.sv
// spi_bus_bridge: SPI mode-0 slave (MSB first, cs_n active low) in front of
// the Controller. Received frames become one-cycle s2b_valid/s2b_data words;
// Controller words accepted on b2s_valid/b2s_ready are shifted out on MISO.
//   clk, reset            : system clock (>= 4x sclk), sync active-high reset
//   spi_sclk/cs_n/mosi    : asynchronous SPI inputs
//   spi_miso              : MSB of the TX shift register
//   s2b_data, s2b_valid   : received word and its one-cycle strobe
//   b2s_data/valid/ready  : Controller word into the TX holding register
//   tx_underrun           : pulse when a frame loads with nothing buffered
module spi_bus_bridge
  import spi_bus_pkg::*;
#(
  parameter int WORD_WIDTH  = WORD_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic [WORD_WIDTH-1:0] s2b_data,
  output logic                  s2b_valid,
  input  logic [WORD_WIDTH-1:0] b2s_data,
  input  logic                  b2s_valid,
  output logic                  b2s_ready,
  output logic                  tx_underrun
);

  localparam int CNT_W = $clog2(WORD_WIDTH);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .reset(reset), .din(spi_sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .reset(reset), .din(spi_cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  // MOSI needs only its level, so it gets a plain chain of the same depth
  // to stay aligned with the sclk strobes.
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  assign mosi_sync_d[0] = spi_mosi;
  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_mosi_chain
    assign mosi_sync_d[gi] = mosi_sync_q[gi-1];
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  frame_state_t          frame_q, frame_d;
  tx_state_t             tx_state_q, tx_state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [WORD_WIDTH-1:0] rx_q, rx_d;
  logic [WORD_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WORD_WIDTH-1:0] hold_q, hold_d;
  logic [WORD_WIDTH-1:0] s2b_data_q, s2b_data_d;
  logic                  reload_q, reload_d;
  logic                  done_q, done_d;
  logic                  s2b_valid_q, s2b_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  tx_load, frame_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      mosi_sync_q <= '0;
      frame_q     <= IDLE;
      tx_state_q  <= EMPTY;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      s2b_data_q  <= '0;
      reload_q    <= 1'b0;
      done_q      <= 1'b0;
      s2b_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      frame_q     <= frame_d;
      tx_state_q  <= tx_state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      s2b_data_q  <= s2b_data_d;
      reload_q    <= reload_d;
      done_q      <= done_d;
      s2b_valid_q <= s2b_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  // Frame FSM: bit counting, RX assembly and TX shift register control.
  always_comb begin
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_shift_d = tx_shift_q;
    reload_d   = reload_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    tx_load    = 1'b0;
    frame_end  = 1'b0;
    case (frame_q)
      IDLE: begin
        if (cs_fall) begin
          frame_d   = SHIFT;
          bit_cnt_d = '0;
          reload_d  = 1'b0;
          tx_load   = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          frame_d   = IDLE;
          bit_cnt_d = '0;
          reload_d  = 1'b0;
          frame_end = 1'b1;
        end else begin
          if (sclk_rise) begin
            rx_d = {rx_q[WORD_WIDTH-2:0], mosi_s};
            if (bit_cnt_q == CNT_W'(WORD_WIDTH - 1)) begin
              bit_cnt_d = '0;
              done_d    = 1'b1;
              reload_d  = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          // With cs_n still low after a full word, the trailing sclk fall
          // starts the next frame: load rather than shift out a stale bit.
          if (sclk_fall) begin
            if (reload_q) begin
              reload_d = 1'b0;
              tx_load  = 1'b1;
            end else begin
              tx_shift_d = {tx_shift_q[WORD_WIDTH-2:0], 1'b0};
            end
          end
        end
      end
      default: frame_d = IDLE;
    endcase
    // The load decision uses the pre-capture holding state, so a word
    // arriving in the same cycle waits for the next frame.
    if (tx_load) begin
      if (tx_state_q == FULL) begin
        tx_shift_d = hold_q;
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
      end
    end
  end

  // TX holding register: the word stays held while SENDING so an aborted
  // frame can retransmit it.
  always_comb begin
    tx_state_d = tx_state_q;
    hold_d     = hold_q;
    case (tx_state_q)
      EMPTY: begin
        if (b2s_valid) begin
          tx_state_d = FULL;
          hold_d     = b2s_data;
        end
      end
      FULL: begin
        if (tx_load) tx_state_d = SENDING;
      end
      SENDING: begin
        if (done_d)         tx_state_d = EMPTY;
        else if (frame_end) tx_state_d = FULL;
      end
      default: tx_state_d = EMPTY;
    endcase
  end

  // One register stage between completion and the bus strobe.
  always_comb begin
    s2b_valid_d = done_q;
    s2b_data_d  = done_q ? rx_q : s2b_data_q;
  end

  assign spi_miso    = tx_shift_q[WORD_WIDTH-1];
  assign s2b_data    = s2b_data_q;
  assign s2b_valid   = s2b_valid_q;
  assign b2s_ready   = (tx_state_q == EMPTY);
  assign tx_underrun = underrun_q;

endmodule

// File: doc/spi_bus_bridge.md
Name: spi_bus_bridge

Overview:
- SPI slave front end sitting directly upstream of the Controller.
- Deserialises 16-bit MOSI frames into single-cycle valid/data words on the spi_2_bus path: commands such as 0x3000 and 0x6000, plus data words.
- Serialises Controller result words, accepted over the bus_2_spi valid/ready handshake, onto MISO.
- SPI mode 0, MSB first, chip-select active low. All SPI pins are sampled asynchronously in the clk domain.

Parameters:
- WORD_WIDTH, 16, bits per SPI frame and bus word.
- SYNC_STAGES, 2, flip-flop stages on spi_sclk, spi_cs_n and spi_mosi.

Ports:
- clk  in  1  system clock; must be ≥ 4× spi_sclk.
- reset  in  1  synchronous, active-high.
- spi_sclk  in  1  SPI clock from the MCU, idle low.
- spi_cs_n  in  1  chip select, active low.
- spi_mosi  in  1  MCU → bridge serial data.
- spi_miso  out  1  bridge → MCU serial data.
- s2b_data  out  WORD_WIDTH  received word, valid with s2b_valid.
- s2b_valid  out  1  one-cycle pulse per completed frame.
- b2s_data  in  WORD_WIDTH  word from the Controller.
- b2s_valid  in  1  Controller offers b2s_data.
- b2s_ready  out  1  bridge can accept a word into its TX holding register.
- tx_underrun  out  1  one-cycle pulse when a frame starts with no TX word buffered.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - spi_miso=0, s2b_data=0, s2b_valid=0, b2s_ready=1, tx_underrun=0.
  - Bit counter=0, shift registers=0, TX holding register empty.
  - Synchroniser flops load their idle levels: sclk=0, cs_n=1.
- Input synchronisation: sclk, cs_n and mosi pass through SYNC_STAGES flops. A registered previous sclk/cs_n value gives rise/fall strobes.
- Frame FSM, state IDLE:
  - Enter on reset or on a synced cs_n rise.
  - On synced cs_n fall, go to SHIFT, clear the bit counter and load the TX shift register.
- Frame FSM, state SHIFT:
  - Each sclk rise strobe shifts synced mosi into the RX shift register LSB and increments the bit counter.
  - Each sclk fall strobe shifts the TX shift register left.
  - spi_miso is always the TX shift register MSB.
- Frame completion:
  - On the rise strobe that brings the bit counter to WORD_WIDTH, the next cycle carries s2b_data = assembled word and s2b_valid = 1 for exactly one cycle.
  - The bit counter wraps to 0. The TX holding register is released: b2s_ready = 1 on the following cycle.
  - s2b_data holds its value until the next completed frame.
- Latency: s2b_valid asserts SYNC_STAGES+2 clk cycles after the 16th sclk rising edge at the pin.
- Back-to-back frames with cs_n held low: the first sclk fall strobe after a completed frame loads the TX shift register instead of shifting.
- TX load rule:
  - If the holding register is full, the shift register takes its content.
  - If it is empty, the shift register loads 0x0000 and tx_underrun pulses for one cycle.
- TX holding register states:
  - EMPTY: b2s_ready=1. The transfer b2s_valid && b2s_ready captures b2s_data and moves to FULL.
  - FULL: b2s_ready=0. A TX load moves to SENDING.
  - SENDING: b2s_ready=0. Frame completion moves to EMPTY.
  - Abort during SENDING (cs_n rise before bit 16) returns to FULL, so the word is retransmitted on the next frame.
- Abort: cs_n rise mid-frame discards the partial RX word (no s2b_valid), clears the bit counter and returns to IDLE.
- Simultaneous events:
  - A capture and a TX load in the same cycle: the load sees the pre-capture state and underruns; the captured word is sent on the next frame.
  - A frame completion and b2s_valid in the same cycle: b2s_ready is still 0, so no capture.
- sclk edges while cs_n is high are ignored.
- Reset mid-frame returns everything to reset values. The partial word is lost and no pulse is generated.

Decomposition:
- Package spi_bus_pkg: WORD_WIDTH default constant, the frame state enum (IDLE, SHIFT), the TX state enum (EMPTY, FULL, SENDING), and command opcode constants CMD_LOAD=16'h3000 and CMD_READ=16'h6000 for bench use.
- Sub-module spi_sync_edge: SYNC_STAGES synchroniser plus rise/fall strobe generation, instantiated for sclk and cs_n (sync only for mosi).

Test Plan:
- MCU sends 0x3000 with sclk = clk/8: s2b_valid high exactly one cycle with s2b_data=0x3000, SYNC_STAGES+2 cycles after the 16th rising edge.
- Controller pushes 0x1234, then MCU clocks one frame sending 0x6000:
  - Before the frame: b2s_ready goes low the cycle after the transfer.
  - During the frame: MISO bits read 0x1234 and s2b_data=0x6000.
  - After the frame: b2s_ready returns high after completion.
- Frame with the TX buffer empty: MISO reads 0x0000, tx_underrun pulses once, RX still delivered.
- Abort after 7 bits, then a full frame 0xABCD: no s2b_valid for the aborted frame, then s2b_data=0xABCD; a buffered TX word 0x5555 is sent on the second frame.
- Two frames 0x1111 and 0x8888 back-to-back without cs_n deassert, with 0x4321 and 0x89AB pushed in time: two s2b_valid pulses in order; MISO reads 0x4321 then 0x89AB.
- Reset asserted at bit 9 of a frame: all outputs at reset values next cycle, no s2b_valid; a subsequent clean frame 0x5000 is received correctly.
